prim_filter_bank: RTL and testbench
===================================

// Module: prim_filter_bank
// PURPOSE
//  Multi-channel, counter-based glitch filter: successor to the fixed-depth shift-register filter.
//  Each channel holds a stable value that changes only after the raw input differs for thresh cycles.
//  Per-channel runtime threshold, enable and direction mode; registered rise/fall event pulses.
//  Sits between pad/GPIO input sync stages and interrupt/wakeup logic.
// PARAMETERS
//  NumChan     8    number of independent channels (>=1)
//  CntWidth    4    counter/threshold width; max filter depth 2**CntWidth-1 cycles
//  ResetValue  '0   [NumChan-1:0] reset value of each channel's stable value
// PORTS
//  clk_i       in   1               clock
//  rst_ni      in   1               synchronous reset, active low
//  enable_i    in   NumChan         per-channel filter enable; 0 = bypass
//  mode_i      in   2*NumChan       per-channel mode, prim_filter_pkg::filt_mode_e, chan c at [2c+:2]
//  thresh_i    in   NumChan*CntWidth per-channel required stable cycles, chan c at [c*CntWidth+:CntWidth]
//  filter_i    in   NumChan         raw inputs, already synchronised to clk_i
//  filter_o    out  NumChan         filtered outputs
//  rise_o      out  NumChan         1-cycle pulse: stable value went 0->1 (filter enabled)
//  fall_o      out  NumChan         1-cycle pulse: stable value went 1->0 (filter enabled)
//  busy_o      out  NumChan         channel counter nonzero (transition pending)
// BEHAVIOUR
//  Clock clk_i; reset synchronous, active low (rst_ni sampled on clk_i rising edge).
//  Reset: stable_q=ResetValue, cnt_q=0, rise_o=fall_o=0, busy_o=0; filter_o=ResetValue when enabled.
//  Per channel c, per cycle, enable_i[c]=1:
//   - filter_i==stable_q: cnt_q<=0 (glitch discarded).
//   - filter_i!=stable_q and direction is unfiltered by mode: stable_q<=filter_i, cnt_q<=0.
//   - filter_i!=stable_q, filtered: if cnt_q+1 >= eff_thresh: stable_q<=filter_i, cnt_q<=0;
//     else cnt_q<=cnt_q+1.
//   - eff_thresh = (thresh_i==0) ? 1 : thresh_i. Counter never exceeds eff_thresh-1; no wrap.
//   - Latency: input changing before edge k and held changes filter_o after edge k+eff_thresh-1.
//   - Threshold lowered mid-count below cnt_q+1: transition on next differing cycle.
//  Modes (filt_mode_e): FiltBoth=0 both edges filtered; FiltRise=1 only 0->1 filtered, 1->0
//   immediate; FiltFall=2 only 1->0 filtered, 0->1 immediate; 3 reserved, treated as FiltBoth.
//  filter_o[c] = enable_i[c] ? stable_q[c] : filter_i[c] (combinational bypass mux).
//  enable_i[c]=0: stable_q<=filter_i each cycle, cnt_q<=0, no rise/fall pulses.
//  Enable 0->1: filtering starts from tracked value; no pulse for the enable event itself.
//  rise_o/fall_o registered: asserted exactly in the cycle filter_o first shows the new value.
//  busy_o[c] = (cnt_q[c]!=0), registered.
//  Reset asserted mid-count: counter and pulses clear on that edge; no partial transition.
//  Channels fully independent; no cross-channel arbitration.
// STRUCTURE
//  prim_filter_pkg: filt_mode_e (2-bit enum FiltBoth/FiltRise/FiltFall), FiltModeW=2.
//  Sub-module prim_filter_chan: one channel (stable_q, cnt_q, pulse flops, mode decode).
//   Parameters CntWidth, ResetValue(1 bit). Top is a generate loop + port slicing only.
// TESTING
//  1 Reset: rst_ni=0 two cycles, ResetValue=8'hA5 -> filter_o=8'hA5, rise/fall/busy=0.
//  2 thresh=4, FiltBoth, ch0 0->1 held -> filter_o[0] rises 4th edge after change; rise_o[0]
//    one cycle; busy_o[0] high for cycles 2-4.
//  3 thresh=4, 3-cycle high glitch on ch1 -> filter_o[1] stays 0, no pulse, busy returns 0.
//  4 FiltRise, thresh=5: 1->0 on ch2 -> filter_o=0 after 1 edge, fall_o pulse; 0->1 needs 5.
//  5 thresh=0 and thresh=15: change reflected after 1 and 15 edges respectively; no overflow.
//  6 enable_i[3]=0: filter_o[3] tracks filter_i combinationally, no pulses; enable mid-count
//    and rst_ni low mid-count both clear cnt; thresh lowered 8->2 at cnt=5 -> next edge flips.

Source files
------------

// File: rtl/prim_filter_pkg.sv
// Shared types for the counter-based glitch filter bank.
// Mode encoding is per channel; value 2'd3 is reserved and decodes as FiltBoth.
package prim_filter_pkg;

    localparam int unsigned FiltModeW = 2;

    typedef enum logic [FiltModeW-1:0] {
        FiltBoth = 2'd0,
        FiltRise = 2'd1,
        FiltFall = 2'd2
    } filt_mode_e;

endpackage

// File: rtl/prim_filter_chan.sv
// One glitch-filter channel: stable value, saturating-free counter, event pulse flops.
// The stable value only moves after the raw input has differed for eff_thresh cycles.
module prim_filter_chan
    import prim_filter_pkg::*;
#(
    parameter int unsigned CntWidth   = 4,
    parameter logic        ResetValue = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic [1:0]          mode_i,
    input  logic [CntWidth-1:0] thresh_i,
    input  logic                filter_i,
    output logic                filter_o,
    output logic                rise_o,
    output logic                fall_o,
    output logic                busy_o
);

    logic                stable_q, stable_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;
    logic                busy_q, busy_d;

    logic                rise_filt_s;
    logic                fall_filt_s;
    logic                dir_filt_s;
    logic [CntWidth:0]   eff_thresh_s;
    logic [CntWidth:0]   cnt_inc_s;

    // Mode decode: which edge directions go through the counter
    always_comb begin
        rise_filt_s = 1'b1;
        fall_filt_s = 1'b1;
        case (mode_i)
            FiltBoth: begin
                rise_filt_s = 1'b1;
                fall_filt_s = 1'b1;
            end
            FiltRise: begin
                rise_filt_s = 1'b1;
                fall_filt_s = 1'b0;
            end
            FiltFall: begin
                rise_filt_s = 1'b0;
                fall_filt_s = 1'b1;
            end
            default: begin
                rise_filt_s = 1'b1;
                fall_filt_s = 1'b1;
            end
        endcase
    end

    // Compare in CntWidth+1 bits so a full-scale threshold cannot wrap the increment
    assign eff_thresh_s = (thresh_i == {CntWidth{1'b0}}) ? {{CntWidth{1'b0}}, 1'b1}
                                                         : {1'b0, thresh_i};
    assign cnt_inc_s    = {1'b0, cnt_q} + {{CntWidth{1'b0}}, 1'b1};
    assign dir_filt_s   = stable_q ? fall_filt_s : rise_filt_s;

    // Next-state: track when bypassed, otherwise count consecutive differing cycles
    always_comb begin
        stable_d = stable_q;
        cnt_d    = {CntWidth{1'b0}};
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (!enable_i) begin
            stable_d = filter_i;
        end else if (filter_i == stable_q) begin
            cnt_d = {CntWidth{1'b0}};
        end else if (!dir_filt_s || (cnt_inc_s >= eff_thresh_s)) begin
            stable_d = filter_i;
            rise_d   = filter_i;
            fall_d   = ~filter_i;
        end else begin
            cnt_d = cnt_inc_s[CntWidth-1:0];
        end
        busy_d = (cnt_d != {CntWidth{1'b0}});
    end

    // State and event flops with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stable_q <= ResetValue;
            cnt_q    <= {CntWidth{1'b0}};
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            busy_q   <= busy_d;
        end
    end

    assign filter_o = enable_i ? stable_q : filter_i;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign busy_o   = busy_q;

endmodule

// File: rtl/prim_filter_bank.sv
// Multi-channel glitch filter bank: independent channels with runtime threshold,
// enable and direction mode. The top only slices the packed ports per channel.
module prim_filter_bank
    import prim_filter_pkg::*;
#(
    parameter int unsigned          NumChan    = 8,
    parameter int unsigned          CntWidth   = 4,
    parameter logic [NumChan-1:0]   ResetValue = {NumChan{1'b0}}
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NumChan-1:0]           enable_i,
    input  logic [FiltModeW*NumChan-1:0] mode_i,
    input  logic [NumChan*CntWidth-1:0]  thresh_i,
    input  logic [NumChan-1:0]           filter_i,
    output logic [NumChan-1:0]           filter_o,
    output logic [NumChan-1:0]           rise_o,
    output logic [NumChan-1:0]           fall_o,
    output logic [NumChan-1:0]           busy_o
);

    for (genvar c = 0; c < NumChan; c++) begin : g_chan
        prim_filter_chan #(
            .CntWidth   (CntWidth),
            .ResetValue (ResetValue[c])
        ) u_chan (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .enable_i (enable_i[c]),
            .mode_i   (mode_i[FiltModeW*c +: FiltModeW]),
            .thresh_i (thresh_i[c*CntWidth +: CntWidth]),
            .filter_i (filter_i[c]),
            .filter_o (filter_o[c]),
            .rise_o   (rise_o[c]),
            .fall_o   (fall_o[c]),
            .busy_o   (busy_o[c])
        );
    end

endmodule

// File: tb/tb_prim_filter_bank.sv
// Directed bench for prim_filter_bank: 8 channels, 4-bit counters, reset value 8'hA5.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_prim_filter_bank;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [7:0]  enable_i;
    logic [15:0] mode_i;
    logic [31:0] thresh_i;
    logic [7:0]  filter_i;
    logic [7:0]  filter_o;
    logic [7:0]  rise_o;
    logic [7:0]  fall_o;
    logic [7:0]  busy_o;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    prim_filter_bank #(
        .NumChan    (8),
        .CntWidth   (4),
        .ResetValue (8'hA5)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_ni),
        .enable_i (enable_i),
        .mode_i   (mode_i),
        .thresh_i (thresh_i),
        .filter_i (filter_i),
        .filter_o (filter_o),
        .rise_o   (rise_o),
        .fall_o   (fall_o),
        .busy_o   (busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp_v);
        end
    endtask

    initial begin
        // Reset with input matching the reset value
        rst_ni   = 1'b0;
        enable_i = 8'hFF;
        mode_i   = 16'h0000;
        thresh_i = 32'h4444_4444;
        filter_i = 8'hA5;
        tick(2);
        chk("rst_filter", filter_o, 8'hA5);
        chk("rst_rise",   rise_o,   8'h00);
        chk("rst_fall",   fall_o,   8'h00);
        chk("rst_busy",   busy_o,   8'h00);

        // Bring ch0 to 0 through bypass; no pulse while disabled
        rst_ni   = 1'b1;
        filter_i = 8'hA4;
        enable_i = 8'hFE;
        #1 chk("bypass_ch0", filter_o, 8'hA4);
        tick(1);
        enable_i = 8'hFF;
        #1 chk("track_ch0", filter_o, 8'hA4);
        chk("track_rise", rise_o, 8'h00);
        chk("track_fall", fall_o, 8'h00);

        // thresh=4, ch0 0->1 held
        filter_i = 8'hA5;
        tick(1);
        chk("t2_e1_filter", filter_o, 8'hA4);
        chk("t2_e1_busy",   busy_o,   8'h01);
        tick(2);
        chk("t2_e3_filter", filter_o, 8'hA4);
        chk("t2_e3_busy",   busy_o,   8'h01);
        tick(1);
        chk("t2_e4_filter", filter_o, 8'hA5);
        chk("t2_e4_rise",   rise_o,   8'h01);
        chk("t2_e4_busy",   busy_o,   8'h00);
        tick(1);
        chk("t2_e5_rise",   rise_o,   8'h00);
        chk("t2_e5_filter", filter_o, 8'hA5);

        // 3-cycle glitch on ch1 is discarded
        filter_i = 8'hA7;
        tick(3);
        chk("t3_glitch_filter", filter_o, 8'hA5);
        chk("t3_glitch_busy",   busy_o,   8'h02);
        filter_i = 8'hA5;
        tick(1);
        chk("t3_end_busy",   busy_o,   8'h00);
        chk("t3_end_filter", filter_o, 8'hA5);
        chk("t3_end_rise",   rise_o,   8'h00);

        // ch2 FiltRise, thresh=5: fall immediate, rise filtered
        mode_i   = 16'h0010;
        thresh_i = 32'h4444_4544;
        filter_i = 8'hA1;
        tick(1);
        chk("t4_fall_filter", filter_o, 8'hA1);
        chk("t4_fall_pulse",  fall_o,   8'h04);
        tick(1);
        chk("t4_fall_clear",  fall_o,   8'h00);
        filter_i = 8'hA5;
        tick(4);
        chk("t4_rise_e4_filter", filter_o, 8'hA1);
        chk("t4_rise_e4_busy",   busy_o,   8'h04);
        tick(1);
        chk("t4_rise_e5_filter", filter_o, 8'hA5);
        chk("t4_rise_e5_pulse",  rise_o,   8'h04);
        chk("t4_rise_e5_busy",   busy_o,   8'h00);

        // ch4 thresh=0 (acts as 1), ch5 thresh=15
        mode_i   = 16'h0000;
        thresh_i = 32'h44F0_4544;
        filter_i = 8'h95;
        tick(1);
        chk("t5_th0_filter", filter_o, 8'hB5);
        chk("t5_th0_rise",   rise_o,   8'h10);
        chk("t5_th0_busy",   busy_o,   8'h20);
        tick(13);
        chk("t5_e14_filter", filter_o, 8'hB5);
        chk("t5_e14_busy",   busy_o,   8'h20);
        tick(1);
        chk("t5_e15_filter", filter_o, 8'h95);
        chk("t5_e15_fall",   fall_o,   8'h20);
        chk("t5_e15_busy",   busy_o,   8'h00);
        tick(1);
        chk("t5_e16_fall",   fall_o,   8'h00);

        // ch3 disabled: combinational tracking, no pulses
        enable_i = 8'hF7;
        filter_i = 8'h9D;
        #1 chk("t6_byp_hi", filter_o, 8'h9D);
        tick(1);
        chk("t6_byp_rise", rise_o, 8'h00);
        filter_i = 8'h95;
        #1 chk("t6_byp_lo", filter_o, 8'h95);
        tick(1);
        chk("t6_byp_fall", fall_o, 8'h00);

        // Disabling mid-count clears the counter; re-enable gives no pulse
        enable_i = 8'hFF;
        filter_i = 8'h9D;
        tick(2);
        chk("t6_en_busy", busy_o, 8'h08);
        enable_i = 8'hF7;
        tick(1);
        chk("t6_dis_busy",   busy_o,   8'h00);
        chk("t6_dis_filter", filter_o, 8'h9D);
        enable_i = 8'hFF;
        tick(1);
        chk("t6_reen_rise",   rise_o,   8'h00);
        chk("t6_reen_busy",   busy_o,   8'h00);
        chk("t6_reen_filter", filter_o, 8'h9D);

        // Reset mid-count: no partial transition
        filter_i = 8'h95;
        tick(2);
        chk("t6_pre_rst_busy", busy_o, 8'h08);
        rst_ni = 1'b0;
        tick(1);
        chk("t6_rst_busy",   busy_o,   8'h00);
        chk("t6_rst_filter", filter_o, 8'hA5);
        chk("t6_rst_fall",   fall_o,   8'h00);
        rst_ni   = 1'b1;
        filter_i = 8'hA5;
        tick(1);
        chk("t6_post_rst_busy",   busy_o,   8'h00);
        chk("t6_post_rst_filter", filter_o, 8'hA5);

        // ch3 thresh 8 lowered to 2 at cnt=5: flips on next edge
        thresh_i = 32'h44F0_8544;
        filter_i = 8'hAD;
        tick(5);
        chk("t6_th8_busy",   busy_o,   8'h08);
        chk("t6_th8_filter", filter_o, 8'hA5);
        thresh_i = 32'h44F0_2544;
        tick(1);
        chk("t6_th2_filter", filter_o, 8'hAD);
        chk("t6_th2_rise",   rise_o,   8'h08);
        chk("t6_th2_busy",   busy_o,   8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
